// File: rtl/flit_sink_monitor.sv
// rtl/flit_sink_monitor.sv - flit stream sink: per-VC framing check, packet/flit stats, data-bus toggle count
module flit_sink_monitor #(
  parameter int DATAW   = 66,
  parameter int TYPEW   = 2,
  parameter int VCHW    = 0,
  parameter logic [TYPEW:0] T_NONE = 3'b000,
  parameter logic [TYPEW:0] T_HEAD = 3'b001,
  parameter logic [TYPEW:0] T_DATA = 3'b010,
  parameter logic [TYPEW:0] T_TAIL = 3'b011,
  parameter int MAX_LEN = 64,
  parameter int CNTW    = 32,
  localparam int NUM_VC = 2 ** (VCHW + 1)
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [DATAW:0]    idata,
  input  logic              ivalid,
  input  logic [VCHW:0]     ivch,
  input  logic              cnt_en,
  input  logic              clr,
  output logic [CNTW-1:0]   pkt_cnt,
  output logic [CNTW-1:0]   flit_cnt,
  output logic [CNTW-1:0]   toggle_cnt,
  output logic [7:0]        last_len,
  output logic [NUM_VC-1:0] vc_busy,
  output logic              err_orphan,
  output logic              err_nohead,
  output logic              err_len
);

  typedef enum logic {S_IDLE, S_BODY} vc_state_e;

  vc_state_e      state_q [NUM_VC];
  vc_state_e      state_d [NUM_VC];
  logic [7:0]     len_q   [NUM_VC];
  logic [7:0]     len_d   [NUM_VC];
  logic [DATAW:0] prev_data;

  logic [TYPEW:0] ftype;
  logic           flit_acc;
  logic           pkt_done;
  logic [7:0]     done_len;
  logic           set_orphan;
  logic           set_nohead;
  logic           set_len;
  logic [DATAW:0] diff;
  logic [CNTW-1:0] pop;

  assign ftype = idata[DATAW:DATAW-TYPEW];

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      state_d[v] = state_q[v];
      len_d[v]   = len_q[v];
    end
    flit_acc   = 1'b0;
    pkt_done   = 1'b0;
    done_len   = 8'd0;
    set_orphan = 1'b0;
    set_nohead = 1'b0;
    set_len    = 1'b0;
    if (ivalid && ftype != T_NONE) begin
      flit_acc = 1'b1;
      unique case (state_q[ivch])
        S_IDLE: begin
          if (ftype == T_HEAD) begin
            state_d[ivch] = S_BODY;
            len_d[ivch]   = 8'd0;
          end else if (ftype == T_DATA || ftype == T_TAIL) begin
            set_orphan = 1'b1;
          end
        end
        S_BODY: begin
          if (ftype == T_HEAD) begin
            // A fresh HEAD abandons the open packet and starts counting anew
            set_nohead  = 1'b1;
            len_d[ivch] = 8'd0;
          end else if (ftype == T_DATA) begin
            if (len_q[ivch] != 8'hFF) len_d[ivch] = len_q[ivch] + 8'd1;
            if (32'(len_q[ivch]) >= MAX_LEN) set_len = 1'b1;
          end else if (ftype == T_TAIL) begin
            state_d[ivch] = S_IDLE;
            pkt_done      = 1'b1;
            done_len      = len_q[ivch];
          end
        end
        default: state_d[ivch] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    diff = idata ^ prev_data;
    pop  = '0;
    for (int i = 0; i <= DATAW; i++) pop = pop + CNTW'(diff[i]);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int v = 0; v < NUM_VC; v++) begin
        state_q[v] <= S_IDLE;
        len_q[v]   <= 8'd0;
      end
      prev_data <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        state_q[v] <= state_d[v];
        len_q[v]   <= len_d[v];
      end
      prev_data <= idata;
    end
  end

  // clr wins over any same-edge update; the framing FSM above ignores it
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pkt_cnt    <= '0;
      flit_cnt   <= '0;
      toggle_cnt <= '0;
      last_len   <= 8'd0;
      err_orphan <= 1'b0;
      err_nohead <= 1'b0;
      err_len    <= 1'b0;
    end else if (clr) begin
      pkt_cnt    <= '0;
      flit_cnt   <= '0;
      toggle_cnt <= '0;
      last_len   <= 8'd0;
      err_orphan <= 1'b0;
      err_nohead <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      if (cnt_en) begin
        if (pkt_done) pkt_cnt  <= pkt_cnt + CNTW'(1);
        if (flit_acc) flit_cnt <= flit_cnt + CNTW'(1);
        toggle_cnt <= toggle_cnt + pop;
      end
      if (pkt_done)   last_len   <= done_len;
      if (set_orphan) err_orphan <= 1'b1;
      if (set_nohead) err_nohead <= 1'b1;
      if (set_len)    err_len    <= 1'b1;
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) vc_busy[v] = (state_q[v] == S_BODY);
  end

endmodule

// File: tb/tb_flit_sink_monitor.sv
// tb/tb_flit_sink_monitor.sv - directed self-checking bench for flit_sink_monitor
module tb_flit_sink_monitor;

  logic        clk = 1'b0;
  logic        rst_;
  logic [66:0] idata;
  logic        ivalid;
  logic [0:0]  ivch;
  logic        cnt_en;
  logic        clr;
  logic [31:0] pkt_cnt;
  logic [31:0] flit_cnt;
  logic [31:0] toggle_cnt;
  logic [7:0]  last_len;
  logic [1:0]  vc_busy;
  logic        err_orphan;
  logic        err_nohead;
  logic        err_len;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] NONE = 3'b000;
  localparam logic [2:0] HEAD = 3'b001;
  localparam logic [2:0] DATA = 3'b010;
  localparam logic [2:0] TAIL = 3'b011;

  flit_sink_monitor dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .cnt_en(cnt_en), .clr(clr), .pkt_cnt(pkt_cnt), .flit_cnt(flit_cnt),
    .toggle_cnt(toggle_cnt), .last_len(last_len), .vc_busy(vc_busy),
    .err_orphan(err_orphan), .err_nohead(err_nohead), .err_len(err_len)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] t, input logic [0:0] vc, input logic [63:0] pl);
    idata  = {t, pl};
    ivalid = 1'b1;
    ivch   = vc;
    step();
    ivalid = 1'b0;
  endtask

  initial begin
    rst_ = 1'b0; idata = '0; ivalid = 1'b0; ivch = '0; cnt_en = 1'b0; clr = 1'b0;
    step(); step();
    chk("rst_pkt", pkt_cnt, 0);
    chk("rst_flit", flit_cnt, 0);
    chk("rst_tog", toggle_cnt, 0);
    chk("rst_busy", vc_busy, 0);
    chk("rst_errs", {err_orphan, err_nohead, err_len}, 0);
    rst_ = 1'b1;
    step();

    // toggle accounting: 0 -> ones -> 0 -> ones -> 0
    cnt_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idata = (i % 2 == 0) ? {67{1'b1}} : '0;
      step();
    end
    chk("tog_268", toggle_cnt, 268);
    chk("tog_pkt", pkt_cnt, 0);
    chk("tog_flit", flit_cnt, 0);

    // window gating: the toggle happens while closed, then window opens on constant data
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_tog", toggle_cnt, 0);
    cnt_en = 1'b0; idata = {67{1'b1}}; step();
    cnt_en = 1'b1; step(); step();
    chk("gate_tog", toggle_cnt, 0);

    // clean packet on VC0
    clr = 1'b1; step(); clr = 1'b0;
    send(HEAD, 1'b0, 64'h1);
    chk("hd_busy", vc_busy, 2'b01);
    for (int i = 0; i < 20; i++) send(DATA, 1'b0, 64'(i) * 64'h0101);
    send(TAIL, 1'b0, 64'hFF);
    chk("pk_pkt", pkt_cnt, 1);
    chk("pk_flit", flit_cnt, 22);
    chk("pk_len", last_len, 20);
    chk("pk_busy", vc_busy, 0);
    chk("pk_errs", {err_orphan, err_nohead, err_len}, 0);
    send(NONE, 1'b0, 64'h0);
    chk("none_flit", flit_cnt, 22);
    chk("none_busy", vc_busy, 0);

    // framing errors
    send(TAIL, 1'b1, 64'h5);
    chk("orph_flag", err_orphan, 1);
    chk("orph_pkt", pkt_cnt, 1);
    send(HEAD, 1'b0, 64'h6);
    send(HEAD, 1'b0, 64'h7);
    chk("nohd_flag", err_nohead, 1);
    chk("nohd_busy", vc_busy, 2'b01);
    send(DATA, 1'b0, 64'h8);
    send(TAIL, 1'b0, 64'h9);
    chk("nohd_len", last_len, 1);
    chk("nohd_pkt", pkt_cnt, 2);

    // clear drops flags and counters, leaves FSM alone
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_errs", {err_orphan, err_nohead, err_len}, 0);
    chk("clr_pkt", pkt_cnt, 0);
    chk("clr_len", last_len, 0);

    // interleaved VCs
    send(HEAD, 1'b0, 64'hA);
    send(HEAD, 1'b1, 64'hB);
    chk("il_busy", vc_busy, 2'b11);
    send(TAIL, 1'b0, 64'hC);
    chk("il_len0", last_len, 0);
    send(DATA, 1'b1, 64'hD);
    send(TAIL, 1'b1, 64'hE);
    chk("il_pkt", pkt_cnt, 2);
    chk("il_len1", last_len, 1);
    chk("il_busy0", vc_busy, 0);
    chk("il_errs", {err_orphan, err_nohead, err_len}, 0);

    // clr on the same edge as a HEAD: flit discarded, FSM still opens
    clr = 1'b1;
    send(HEAD, 1'b0, 64'h1);
    clr = 1'b0;
    chk("clrhd_flit", flit_cnt, 0);
    chk("clrhd_busy", vc_busy, 2'b01);
    for (int i = 0; i < 64; i++) send(DATA, 1'b0, 64'(i));
    chk("len64_err", err_len, 0);
    chk("len64_flit", flit_cnt, 64);
    send(DATA, 1'b0, 64'h40);
    chk("len65_err", err_len, 1);
    send(TAIL, 1'b0, 64'h0);
    chk("len65_last", last_len, 65);
    chk("len65_pkt", pkt_cnt, 1);
    chk("len65_flit", flit_cnt, 66);

    // asynchronous reset mid-packet
    send(HEAD, 1'b1, 64'h3);
    chk("mr_busy", vc_busy, 2'b10);
    #2 rst_ = 1'b0;
    #1;
    chk("ar_busy", vc_busy, 0);
    chk("ar_pkt", pkt_cnt, 0);
    chk("ar_errs", {err_orphan, err_nohead, err_len}, 0);
    rst_ = 1'b1;
    send(TAIL, 1'b1, 64'h4);
    chk("ar_orph", err_orphan, 1);
    chk("ar_pkt2", pkt_cnt, 0);
    chk("ar_flit", flit_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
